// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// ALU operation codes, controller states and datapath select values.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
    ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_LUI = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_MEM = 3'd3, ST_WB = 3'd4, ST_ERR = 3'd5
  } state_e;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] WDATA_ALU = 2'd0;
  localparam logic [1:0] WDATA_MEM = 2'd1;
  localparam logic [1:0] WDATA_PC4 = 2'd2;

  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_SEXT = 2'd2;
  localparam logic [1:0] SRC_B_ZEXT = 2'd3;

  localparam logic [1:0] PC_SRC_ALU = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;
  localparam logic [1:0] PC_SRC_RS  = 2'd3;

endpackage

// File: rtl/mips_alu_dec.sv
// Maps (op, funct) to an ALU operation and flags encodings the core does not
// implement; the controller treats !valid as an illegal instruction.
module mips_alu_dec
  import mips_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic [OP_W-1:0] op,
  input  logic [FN_W-1:0] funct,
  output alu_op_e         alu_op,
  output logic            valid
);

  // Opcode/funct decode; jumps map to ADD since their ALU result is unused.
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_JR: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU:        alu_op = ALU_SUB;
          FN_AND:                 alu_op = ALU_AND;
          FN_OR:                  alu_op = ALU_OR;
          FN_XOR:                 alu_op = ALU_XOR;
          FN_NOR:                 alu_op = ALU_NOR;
          FN_SLT:                 alu_op = ALU_SLT;
          FN_SLL:                 alu_op = ALU_SLL;
          FN_SRL:                 alu_op = ALU_SRL;
          default:                valid  = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_LW, OP_SW, OP_ADDI: alu_op = ALU_ADD;
      OP_BEQ, OP_BNE:                      alu_op = ALU_SUB;
      OP_SLTI:                             alu_op = ALU_SLT;
      OP_ANDI:                             alu_op = ALU_AND;
      OP_ORI:                              alu_op = ALU_OR;
      OP_XORI:                             alu_op = ALU_XOR;
      OP_LUI:                              alu_op = ALU_LUI;
      default:                             valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS controller: sequences IF/ID/EX/MEM/WB over the shared
// datapath. Outputs are forced to zero while rstb is high.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic            clkb,
  input  logic            rstb,
  input  logic [OP_W-1:0] op,
  input  logic [FN_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            iord,
  output logic            write_reg,
  output logic [1:0]      reg_dst,
  output logic [1:0]      wdata_sel,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [3:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic [2:0]      state,
  output logic            illegal
);

  state_e          state_r, state_nxt_s;
  logic [OP_W-1:0] op_r, dec_op_s;
  logic [FN_W-1:0] funct_r, dec_funct_s;
  logic            illegal_r, dec_valid_s;
  alu_op_e         dec_alu_op_s, alu_op_s;
  logic            is_r_s, is_jr_s, is_jal_s, is_beq_s, is_br_s, is_lw_s, is_sw_s;
  logic            is_sext_s, is_zext_s;

  // In ID the live IR fields are decoded; afterwards the latched copy is used.
  assign dec_op_s    = (state_r == ST_ID) ? op : op_r;
  assign dec_funct_s = (state_r == ST_ID) ? funct : funct_r;

  mips_alu_dec #(.OP_W(OP_W), .FN_W(FN_W)) u_alu_dec (
    .op     (dec_op_s),
    .funct  (dec_funct_s),
    .alu_op (dec_alu_op_s),
    .valid  (dec_valid_s)
  );

  assign is_r_s    = (op_r == OP_RTYPE);
  assign is_jr_s   = is_r_s && (funct_r == FN_JR);
  assign is_jal_s  = (op_r == OP_JAL);
  assign is_beq_s  = (op_r == OP_BEQ);
  assign is_br_s   = is_beq_s || (op_r == OP_BNE);
  assign is_lw_s   = (op_r == OP_LW);
  assign is_sw_s   = (op_r == OP_SW);
  assign is_sext_s = (op_r == OP_ADDI) || (op_r == OP_SLTI);
  assign is_zext_s = (op_r == OP_ANDI) || (op_r == OP_ORI) || (op_r == OP_XORI) ||
                     (op_r == OP_LUI);

  // State register, ID-stage op/funct latch and sticky illegal flag.
  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      state_r   <= ST_IF;
      op_r      <= '0;
      funct_r   <= '0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_ID) begin
        op_r    <= op;
        funct_r <= funct;
        if (!dec_valid_s) begin
          illegal_r <= 1'b1;
        end
      end
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_nxt_s = state_r;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    write_reg   = 1'b0;
    reg_dst     = REG_DST_RT;
    wdata_sel   = WDATA_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRC_B_RT;
    alu_op_s    = ALU_ADD;
    pc_src      = PC_SRC_ALU;
    if (rstb) begin
      state_nxt_s = ST_IF;
    end else begin
      case (state_r)
        ST_IF: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          if (mem_ready) begin
            ir_write    = 1'b1;
            pc_write    = 1'b1;
            state_nxt_s = ST_ID;
          end else begin
            state_nxt_s = ST_IF;
          end
        end
        ST_ID: begin
          alu_src_b = SRC_B_SEXT;
          if (!dec_valid_s) begin
            state_nxt_s = ST_ERR;
          end else if (op == OP_J) begin
            pc_write    = 1'b1;
            pc_src      = PC_SRC_JMP;
            state_nxt_s = ST_IF;
          end else begin
            state_nxt_s = ST_EX;
          end
        end
        ST_EX: begin
          alu_op_s = dec_alu_op_s;
          if (is_jr_s) begin
            pc_write    = 1'b1;
            pc_src      = PC_SRC_RS;
            state_nxt_s = ST_IF;
          end else if (is_jal_s) begin
            pc_write    = 1'b1;
            pc_src      = PC_SRC_JMP;
            state_nxt_s = ST_WB;
          end else if (is_br_s) begin
            alu_src_a   = 1'b1;
            alu_op_s    = ALU_SUB;
            pc_src      = PC_SRC_BR;
            pc_write    = is_beq_s ? zero : !zero;
            state_nxt_s = ST_IF;
          end else if (is_lw_s || is_sw_s) begin
            alu_src_a   = 1'b1;
            alu_src_b   = SRC_B_SEXT;
            alu_op_s    = ALU_ADD;
            state_nxt_s = ST_MEM;
          end else if (is_sext_s) begin
            alu_src_a   = 1'b1;
            alu_src_b   = SRC_B_SEXT;
            state_nxt_s = ST_WB;
          end else if (is_zext_s) begin
            alu_src_a   = 1'b1;
            alu_src_b   = SRC_B_ZEXT;
            state_nxt_s = ST_WB;
          end else begin
            alu_src_a   = 1'b1;
            alu_src_b   = SRC_B_RT;
            state_nxt_s = ST_WB;
          end
        end
        ST_MEM: begin
          iord      = 1'b1;
          mem_read  = is_lw_s;
          mem_write = is_sw_s;
          if (mem_ready) begin
            state_nxt_s = is_lw_s ? ST_WB : ST_IF;
          end else begin
            state_nxt_s = ST_MEM;
          end
        end
        ST_WB: begin
          write_reg   = 1'b1;
          state_nxt_s = ST_IF;
          if (is_r_s) begin
            reg_dst = REG_DST_RD;
          end else if (is_jal_s) begin
            reg_dst   = REG_DST_RA;
            wdata_sel = WDATA_PC4;
          end else if (is_lw_s) begin
            wdata_sel = WDATA_MEM;
          end else begin
            reg_dst = REG_DST_RT;
          end
        end
        ST_ERR: state_nxt_s = ST_ERR;
        default: state_nxt_s = ST_IF;
      endcase
    end
  end

  assign alu_op  = alu_op_s;
  assign state   = state_r;
  assign illegal = illegal_r;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench: each stimulus cycle queues its expected output vector; a
// monitor pops and compares at the following negedge.
module tb_mips_mc_ctrl;

  logic       clkb = 1'b0;
  logic       rstb = 1'b1;
  logic [5:0] op = 6'h00, funct = 6'h00;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, iord, write_reg, alu_src_a, illegal;
  logic [1:0] reg_dst, wdata_sel, alu_src_b, pc_src;
  logic [3:0] alu_op;
  logic [2:0] state;

  logic [22:0] exp_q[$];
  string       name_q[$];
  int          push_cnt = 0, chk_cnt = 0, pass_cnt = 0;
  logic        done = 1'b0;
  logic [22:0] act, e_if, e_ifw, e_id, e_rst, e_err;

  mips_mc_ctrl #(.OP_W(6), .FN_W(6)) dut (
    .clkb(clkb), .rstb(rstb), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .write_reg(write_reg), .reg_dst(reg_dst), .wdata_sel(wdata_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .illegal(illegal)
  );

  always #5 clkb = ~clkb;

  assign act = {state, illegal, pc_write, ir_write, mem_read, mem_write, iord, write_reg,
                reg_dst, wdata_sel, alu_src_a, alu_src_b, alu_op, pc_src};

  // Field order: state, illegal, pc_write, ir_write, mem_read, mem_write, iord,
  // write_reg, reg_dst, wdata_sel, alu_src_a, alu_src_b, alu_op, pc_src.
  function automatic logic [22:0] mk(input int st, il, pcw, irw, mr, mw, io, wr,
                                     input int rd, ws, sa, sb, ao, ps);
    logic [31:0] v[14];
    v = '{st, il, pcw, irw, mr, mw, io, wr, rd, ws, sa, sb, ao, ps};
    return {v[0][2:0], v[1][0], v[2][0], v[3][0], v[4][0], v[5][0], v[6][0], v[7][0],
            v[8][1:0], v[9][1:0], v[10][0], v[11][1:0], v[12][3:0], v[13][1:0]};
  endfunction

  task automatic cyc(input string nm, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic r, input logic rb, input logic [22:0] e);
    @(posedge clkb);
    #1;
    op = o; funct = f; zero = z; mem_ready = r; rstb = rb;
    exp_q.push_back(e);
    name_q.push_back(nm);
    push_cnt++;
  endtask

  // Monitor: compare one queued expectation per negedge, then summarise.
  initial begin
    logic [22:0] e;
    string       n;
    while (!done) begin
      @(negedge clkb);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk_cnt++;
        if (act === e) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
    chk_cnt++;
    if (exp_q.size() == 0 && chk_cnt - 1 == push_cnt) pass_cnt++;
    else $display("FAIL drain: got %0d checked expected %0d", chk_cnt - 1, push_cnt);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    e_if  = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    e_ifw = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    e_id  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    e_rst = 23'd0;
    e_err = mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc("reset0", 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, e_rst);
    cyc("reset1", 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, e_rst);
    // add; op/funct scrambled after ID to prove they were latched
    cyc("add_if", 6'h00, 6'h20, 1'b0, 1'b1, 1'b0, e_if);
    cyc("add_id", 6'h00, 6'h20, 1'b0, 1'b1, 1'b0, e_id);
    cyc("add_ex", 6'h3F, 6'h3F, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("add_wb", 6'h3F, 6'h3F, 1'b0, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    // nor
    cyc("nor_if", 6'h00, 6'h27, 1'b0, 1'b1, 1'b0, e_if);
    cyc("nor_id", 6'h00, 6'h27, 1'b0, 1'b1, 1'b0, e_id);
    cyc("nor_ex", 6'h00, 6'h27, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0));
    cyc("nor_wb", 6'h00, 6'h27, 1'b0, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    // lw with two wait cycles in MEM
    cyc("lw_if", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("lw_id", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    cyc("lw_ex", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    cyc("lw_mw0", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw_mw1", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw_mem", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw_wb", 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    // sw with a slow fetch
    cyc("sw_ifw", 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, e_ifw);
    cyc("sw_if", 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("sw_id", 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    cyc("sw_ex", 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    cyc("sw_mem", 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, mk(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    // beq taken / not taken, bne taken
    cyc("beq1_if", 6'h04, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("beq1_id", 6'h04, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    cyc("beq1_ex", 6'h04, 6'h00, 1'b1, 1'b1, 1'b0, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    cyc("beq0_if", 6'h04, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("beq0_id", 6'h04, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    cyc("beq0_ex", 6'h04, 6'h00, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    cyc("bne_if", 6'h05, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("bne_id", 6'h05, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    cyc("bne_ex", 6'h05, 6'h00, 1'b0, 1'b1, 1'b0, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    // j, jal, jr
    cyc("j_if", 6'h02, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("j_id", 6'h02, 6'h00, 1'b0, 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2));
    cyc("jal_if", 6'h03, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("jal_id", 6'h03, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    cyc("jal_ex", 6'h03, 6'h00, 1'b0, 1'b1, 1'b0, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("jal_wb", 6'h03, 6'h00, 1'b0, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0));
    cyc("jr_if", 6'h00, 6'h08, 1'b0, 1'b1, 1'b0, e_if);
    cyc("jr_id", 6'h00, 6'h08, 1'b0, 1'b1, 1'b0, e_id);
    cyc("jr_ex", 6'h00, 6'h08, 1'b0, 1'b1, 1'b0, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    // ori, slti
    cyc("ori_if", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("ori_id", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    cyc("ori_ex", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0));
    cyc("ori_wb", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc("slti_if", 6'h0A, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("slti_id", 6'h0A, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    cyc("slti_ex", 6'h0A, 6'h00, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 6, 0));
    cyc("slti_wb", 6'h0A, 6'h00, 1'b0, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // reset raised 1ns into WB: same-cycle sample must already show IF, all zero
    cyc("orir_if", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("orir_id", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    cyc("orir_ex", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0));
    cyc("orir_wbrst", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b1, e_rst);
    cyc("orir_rel", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("orir_id2", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    cyc("orir_ex2", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0));
    cyc("orir_wb2", 6'h0D, 6'h00, 1'b0, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // illegal opcode: terminal ERR under toggling inputs, exited only by rstb
    cyc("ilop_if", 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, e_if);
    cyc("ilop_id", 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, e_id);
    for (int i = 0; i < 10; i++) begin
      cyc("ilop_err", 6'h3F, 6'h00, i[0], ~i[1], 1'b0, e_err);
    end
    cyc("ilop_rst", 6'h3F, 6'h00, 1'b0, 1'b1, 1'b1, e_rst);
    cyc("ilop_rel", 6'h00, 6'h20, 1'b0, 1'b1, 1'b0, e_if);
    // illegal funct under R-type opcode
    cyc("ilfn_id", 6'h00, 6'h3F, 1'b0, 1'b1, 1'b0, e_id);
    cyc("ilfn_err", 6'h00, 6'h20, 1'b0, 1'b1, 1'b0, e_err);
    cyc("ilfn_rst", 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, e_rst);
    cyc("ilfn_rel", 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, e_ifw);

    repeat (3) @(posedge clkb);
    done = 1'b1;
  end

endmodule
